// File: rtl/button_stepper_if.sv
// Step-pulse link from the button stepper (master) to the ALU mode/display block (slave).
// selector is a one-cycle pulse with no back-pressure; mode, busy and done are registered levels/pulses.
interface button_stepper_if #(
    parameter int NUM_MODES = 10
);
    localparam int MW = $clog2(NUM_MODES);

    logic          selector;
    logic [MW-1:0] mode;
    logic          busy;
    logic          done;

    modport master (output selector, output mode, output busy, output done);
    modport slave  (input  selector, input  mode, input  busy, input  done);
endinterface

// File: rtl/button_stepper.sv
// Push-button conditioner (sync, debounce, rising edge) plus auto-step sequencer driving
// one-cycle selector pulses and a wrapping mode index. All outputs are registered.
module button_stepper #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 11,
    parameter int AUTO_COUNT      = 12,
    parameter int NUM_MODES       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             auto_en,
    button_stepper_if.master sel_if,
    output logic [1:0]       o_dbg_state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(AUTO_PERIOD);
    localparam int NW = $clog2(AUTO_COUNT + 1);
    localparam int MW = $clog2(NUM_MODES);

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_LAST  = PW'(AUTO_PERIOD - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(AUTO_COUNT);
    localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_MODES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AUTO = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic          r_s1, r_s2, r_stable, r_stable_q, r_armed;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_pcnt;
    logic [NW-1:0] r_n;
    logic [1:0]    r_state;
    logic          r_selector, r_busy, r_done;
    logic [MW-1:0] r_mode;

    logic          w_manual_req, w_pulse, w_start;
    logic [1:0]    w_next_state;

    // Abort has priority over the normal end of a sequence; auto start beats a manual request.
    always_comb begin
        w_manual_req = r_stable & ~r_stable_q;
        w_next_state = r_state;
        w_pulse      = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (auto_en && r_armed) begin
                    w_next_state = S_AUTO;
                    w_start      = 1'b1;
                end else begin
                    w_pulse = w_manual_req;
                end
            end
            S_AUTO: begin
                if (!auto_en) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_pulse = (r_pcnt == '0);
                    if (r_pcnt == PCNT_LAST && r_n == N_LAST) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_cnt      <= '0;
            r_pcnt     <= '0;
            r_n        <= '0;
            r_armed    <= 1'b0;
            r_state    <= S_IDLE;
            r_selector <= 1'b0;
            r_mode     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_s1       <= btn_raw;
            r_s2       <= r_s1;
            r_stable_q <= r_stable;

            if (r_s2 != r_stable) begin
                if (r_cnt == DB_LAST) begin
                    r_stable <= r_s2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_armed <= 1'b0;
                end else if (!auto_en) begin
                    r_armed <= 1'b1;
                end
            end

            if (w_start) begin
                r_pcnt <= '0;
                r_n    <= '0;
            end else if (r_state == S_AUTO) begin
                r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + PW'(1);
                if (w_pulse) begin
                    r_n <= r_n + NW'(1);
                end
            end

            r_state    <= w_next_state;
            r_selector <= w_pulse;
            if (w_pulse) begin
                r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + MW'(1);
            end
            // busy/done lag the state by one edge so every output stays a plain flop.
            r_busy <= (r_state == S_AUTO);
            r_done <= (r_state == S_DONE);
        end
    end

    assign sel_if.selector = r_selector;
    assign sel_if.mode     = r_mode;
    assign sel_if.busy     = r_busy;
    assign sel_if.done     = r_done;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_button_stepper.sv
// Directed bench for button_stepper: reset, clean press, bounce rejection, auto run,
// abort/restart and a press dropped during an auto sequence.
module tb_button_stepper;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       auto_en;
    logic [1:0] dbg_state;

    button_stepper_if #(.NUM_MODES(10)) u_if ();

    button_stepper #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD(11),
        .AUTO_COUNT(12),
        .NUM_MODES(10)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .auto_en    (auto_en),
        .sel_if     (u_if),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_done_q[$];
    int          m_mode = 0;
    logic        prev_sel = 1'b0;
    logic        prev_busy = 1'b0;
    int unsigned busy_total = 0;
    int unsigned busy_rise = 0;
    int unsigned a;
    int unsigned k;
    int unsigned snap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One negedge of observation: pulse/done timing against the expected queues, mode model.
    task automatic observe();
        if (u_if.selector) begin
            check_eq("back_to_back", {31'd0, prev_sel}, 32'd0);
            if (exp_q.size() == 0) check_eq("unexpected_pulse", cyc, 32'd0);
            else                   check_eq("pulse_edge", cyc, exp_q.pop_front());
            m_mode = (m_mode == 9) ? 0 : m_mode + 1;
        end
        prev_sel = u_if.selector;
        check_eq("mode", {28'd0, u_if.mode}, m_mode);
        if (u_if.done) begin
            if (exp_done_q.size() == 0) check_eq("unexpected_done", cyc, 32'd0);
            else                        check_eq("done_edge", cyc, exp_done_q.pop_front());
        end
        if (u_if.busy) busy_total++;
        if (u_if.busy && !prev_busy) busy_rise = cyc;
        prev_busy = u_if.busy;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            observe();
        end
    endtask

    task automatic start_auto(input int n_pulses, input logic with_done);
        auto_en = 1'b0;
        tick(3);
        auto_en = 1'b1;
        a = cyc + 1;
        snap = busy_total;
        for (int i = 0; i < n_pulses; i++) exp_q.push_back(a + 1 + 11 * i);
        if (with_done) exp_done_q.push_back(a + 133);
    endtask

    initial begin
        // Reset with button and auto_en both held high.
        rst = 1'b1;
        btn_raw = 1'b1;
        auto_en = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_selector", {31'd0, u_if.selector}, 32'd0);
        check_eq("rst_mode", {28'd0, u_if.mode}, 32'd0);
        check_eq("rst_busy", {31'd0, u_if.busy}, 32'd0);
        check_eq("rst_done", {31'd0, u_if.done}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        btn_raw = 1'b0;
        tick(30);
        check_eq("no_auto_without_rearm", busy_total, 32'd0);
        check_eq("idle_after_rst", {30'd0, dbg_state}, 32'd0);

        // Clean press: pulse at k+6, nothing on release.
        btn_raw = 1'b1;
        k = cyc + 1;
        exp_q.push_back(k + 6);
        tick(20);
        btn_raw = 1'b0;
        tick(20);
        check_eq("press_pulse_seen", exp_q.size(), 32'd0);
        check_eq("press_mode", {28'd0, u_if.mode}, 32'd1);

        // Bounce: 3-high/1-low runs never qualify, then a 6-cycle run does.
        for (int i = 0; i < 10; i++) begin
            btn_raw = 1'b1;
            tick(3);
            btn_raw = 1'b0;
            tick(1);
        end
        tick(5);
        check_eq("bounce_mode", {28'd0, u_if.mode}, 32'd1);
        btn_raw = 1'b1;
        k = cyc + 1;
        exp_q.push_back(k + 6);
        tick(6);
        btn_raw = 1'b0;
        tick(15);
        check_eq("bounce_pulse_seen", exp_q.size(), 32'd0);
        check_eq("bounce_mode_after", {28'd0, u_if.mode}, 32'd2);

        // Full auto run: 12 pulses, done at a+133, busy 132 cycles, mode 2 -> 4.
        start_auto(12, 1'b1);
        tick(150);
        check_eq("auto_pulses_seen", exp_q.size(), 32'd0);
        check_eq("auto_done_seen", exp_done_q.size(), 32'd0);
        check_eq("auto_busy_len", busy_total - snap, 32'd132);
        check_eq("auto_busy_rise", busy_rise, a + 1);
        check_eq("auto_mode", {28'd0, u_if.mode}, 32'd4);
        tick(20);

        // Abort right after the 3rd pulse, then a fresh full sequence.
        start_auto(3, 1'b0);
        tick(24);
        auto_en = 1'b0;
        tick(2);
        check_eq("abort_busy_low", {31'd0, u_if.busy}, 32'd0);
        tick(30);
        check_eq("abort_pulses_seen", exp_q.size(), 32'd0);
        check_eq("abort_busy_len", busy_total - snap, 32'd24);
        check_eq("abort_mode", {28'd0, u_if.mode}, 32'd7);
        auto_en = 1'b1;
        a = cyc + 1;
        snap = busy_total;
        for (int i = 0; i < 12; i++) exp_q.push_back(a + 1 + 11 * i);
        exp_done_q.push_back(a + 133);
        tick(150);
        check_eq("restart_pulses_seen", exp_q.size(), 32'd0);
        check_eq("restart_done_seen", exp_done_q.size(), 32'd0);
        check_eq("restart_busy_len", busy_total - snap, 32'd132);
        check_eq("restart_mode", {28'd0, u_if.mode}, 32'd9);

        // Press landing mid-sequence is dropped; timing of the run is unchanged.
        start_auto(12, 1'b1);
        tick(40);
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(100);
        check_eq("press_in_auto_pulses", exp_q.size(), 32'd0);
        check_eq("press_in_auto_done", exp_done_q.size(), 32'd0);
        check_eq("press_in_auto_mode", {28'd0, u_if.mode}, 32'd1);
        check_eq("final_state", {30'd0, dbg_state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/button_stepper.md
# button_stepper

Initiator side of the ALU mode-selector interface. Conditions a raw push-button (synchronize, debounce, rising-edge detect) into clean one-cycle `selector` pulses and keeps a wrapping `mode` index in step with every pulse. Also has an auto-step sequencer that emits a fixed-length, fixed-period pulse train for board demos and regression. It sits between the board push-button and the `selector` input of the ALU mode/display block.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a new button level (≥1).
- `AUTO_PERIOD`, 11: cycles between consecutive auto-generated pulses (≥2).
- `AUTO_COUNT`, 12: pulses per auto sequence (≥1).
- `NUM_MODES`, 10: modulus of `mode` (≥2).
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  1  asynchronous, bouncing push-button level, active high.
- `auto_en`  in  1  level; a rising transition seen in IDLE starts an auto sequence; low aborts it.
- `selector`  out  1  one-cycle step pulse to the ALU mode block.
- `mode`  out  $clog2(NUM_MODES)  current mode index, advances with each `selector` pulse.
- `busy`  out  1  high while an auto sequence runs.
- `done`  out  1  one-cycle pulse when an auto sequence completes normally.

## Operation
- Synchronizer: two flops `s1`→`s2` on `btn_raw`.
- Debouncer: register `stable`, counter `cnt`. When `s2 != stable`, `cnt` increments. When it would reach `DEBOUNCE_CYCLES`, `stable <= s2` and `cnt <= 0`. When `s2 == stable`, `cnt <= 0`.
- Manual request: `stable & ~stable_q`, where `stable_q` is the prior-cycle `stable`. Falling edges produce nothing.
- Re-arm flag `armed`: set when `auto_en == 0` is sampled in IDLE. Cleared when a sequence starts.
- FSM states:
  - IDLE: if `auto_en && armed`, go to AUTO, load `pcnt <= 0` and `n <= 0`, and issue the first pulse on the next edge. Otherwise a manual request issues a pulse.
  - AUTO: issue a pulse when `pcnt == 0`. `pcnt` counts 0..AUTO_PERIOD-1 and wraps. After pulse number AUTO_COUNT, when `pcnt` wraps, go to DONE. If `auto_en == 0`, go to IDLE immediately. The abort issues no pulse and no `done`.
  - DONE: for one cycle, then go to IDLE.
- Manual requests in AUTO or DONE are dropped, not queued. If a manual request and an auto start occur in the same cycle, auto wins and the manual request is dropped.
- `mode`: on each pulse, `mode <= (mode == NUM_MODES-1) ? 0 : mode+1`. It never changes without a pulse. Abort does not change it.
- Reset, from any state: state=IDLE; `s1`, `s2`, `stable`, `stable_q`, `cnt`, `pcnt`, `n`, `armed` = 0; all outputs 0.

## Timing
- All outputs are registered, with no combinational path from any input.
- Manual latency: let edge k be the first edge sampling `btn_raw=1`, with the input held clean.
  - `s2=1` at edge k+1.
  - `stable=1` at edge k+1+DEBOUNCE_CYCLES.
  - `selector=1` and `mode` updated at edge k+2+DEBOUNCE_CYCLES.
  - `selector` clears at the following edge.
- Auto: let edge a be the edge where IDLE samples `auto_en=1` with `armed=1`.
  - `busy` rises at a+1.
  - Pulses occur at edges a+1+i·AUTO_PERIOD, for i = 0..AUTO_COUNT-1.
  - `done=1` and `busy=0` at edge a+1+AUTO_COUNT·AUTO_PERIOD. `done` clears one edge later.
- Abort: if `auto_en=0` is sampled at edge b in AUTO, `busy=0` at edge b+1 and no pulse at or after b+1.
- Pulses never occur on consecutive cycles.

## Test plan
Defaults apply in every scenario: DEBOUNCE_CYCLES=4, AUTO_PERIOD=11, AUTO_COUNT=12, NUM_MODES=10.
1. Reset with `btn_raw=1` and `auto_en=1` held -> all outputs 0 during and after `rst`. No auto start until `auto_en` goes low then high.
2. Clean press, `btn_raw` high 20 cycles then low -> exactly one `selector` pulse at edge k+6, `mode` 0→1. No pulse on release.
3. Bounce, `btn_raw` high runs of 3 cycles separated by 1-cycle lows, 10 times -> no pulse, `mode` stays 0. Then a 6-cycle high run -> one pulse.
4. Auto run, `auto_en` 0 then 1 at edge a -> 12 pulses at a+1, a+12, …, a+122. `mode` passes 9→0 and ends at 2. `done` one cycle at a+133. `busy` high for exactly 132 cycles.
5. Abort, `auto_en` dropped right after the 3rd pulse -> `busy` low next edge, no further pulses, no `done`, `mode`=3. Raising `auto_en` again starts a fresh 12-pulse sequence.
6. Press during auto: a clean press whose debounced edge lands mid-sequence -> dropped. Total pulse count stays 12 and timing is unchanged.
